// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled tick, start/pause/clear control.
// Periodic reload mode when COUNTDOWN_AUTO_RELOAD_EN is defined.
module countdown_timer #(
  parameter int CLK_PER_MS = 50_000,
  parameter int TICK_MS    = 1000,
  parameter int CNT_W      = 11
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt_out,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  localparam int TOP = CLK_PER_MS * TICK_MS;
  localparam int PW  = (TOP > 1) ? $clog2(TOP) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TOP - 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [PW-1:0]    psc;
  logic [CNT_W-1:0] reload;
  logic             dec;
  logic             last;
  logic             rearm;

  assign dec   = (state == RUN) && (psc == PMAX);
  assign last  = (cnt_out == CNT_W'(1));
  assign rearm = AUTO_RELOAD && (reload != '0);

  // Control FSM, prescaler, count and registered pulse outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      psc     <= '0;
      cnt_out <= '0;
      reload  <= '0;
      busy    <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        cnt_out <= '0;
        psc     <= '0;
        state   <= IDLE;
        busy    <= 1'b0;
      end else if (load) begin
        cnt_out <= load_val;
        reload  <= load_val;
        psc     <= '0;
        state   <= IDLE;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && cnt_out != '0) begin
              psc   <= '0;
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            psc <= dec ? '0 : psc + PW'(1);
            if (dec && last) begin
              tick <= 1'b1;
              done <= 1'b1;
              if (rearm) begin
                cnt_out <= reload;
                if (pause) state <= PAUSE;
              end else begin
                cnt_out <= '0;
                state   <= DONE;
                busy    <= 1'b0;
              end
            end else begin
              if (dec && cnt_out != '0) begin
                tick    <= 1'b1;
                cnt_out <= cnt_out - CNT_W'(1);
              end
              if (pause) state <= PAUSE;
            end
          end
          PAUSE: begin
            if (start) state <= RUN;
          end
          DONE: begin
            cnt_out <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, hand sequences, random vs model.
// Build with COUNTDOWN_AUTO_RELOAD_EN to exercise periodic mode.
module tb_countdown_timer;

  localparam int CPM = 4;
  localparam int TMS = 2;
  localparam int W   = 11;
  localparam int P   = CPM * TMS;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         sys_clk;
  logic         sys_rst_n;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         clear;
  logic [W-1:0] cnt_out;
  logic         busy;
  logic         tick;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  countdown_timer #(
    .CLK_PER_MS(CPM),
    .TICK_MS   (TMS),
    .CNT_W     (W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .cnt_out  (cnt_out),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    bit ld;
    int lv;
    bit st;
    bit ps;
    bit cl;
    int ext;
    int cnt;
    bit bsy;
    bit tk;
    bit dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit ld, int lv, bit st, bit ps, bit cl, int ext,
                     int cnt, bit bsy, bit tk, bit dn);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.cl = cl;
    v.ext = ext; v.cnt = cnt; v.bsy = bsy; v.tk = tk; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit ld, int lv, bit st, bit ps, bit cl);
    load = ld; load_val = W'(lv); start = st; pause = ps; clear = cl;
    @(posedge sys_clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  // Reference model: counts RUN cycles and derives everything from that
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  int m_mode;
  int m_reload;
  int m_idle_cnt;
  int m_base;
  int m_run;
  bit m_tick;
  bit m_done;

  task automatic model_reset();
    m_mode = M_IDLE; m_reload = 0; m_idle_cnt = 0;
    m_base = 0; m_run = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_step(bit ld, int lv, bit st, bit ps, bit cl);
    int k;
    m_tick = 0;
    m_done = 0;
    if (cl) begin
      m_mode = M_IDLE;
      m_idle_cnt = 0;
    end else if (ld) begin
      m_mode = M_IDLE;
      m_idle_cnt = lv;
      m_reload = lv;
    end else begin
      case (m_mode)
        M_IDLE: if (st && m_idle_cnt != 0) begin
          m_mode = M_RUN;
          m_base = m_idle_cnt;
          m_run = 0;
        end
        M_RUN: begin
          m_run++;
          if (m_run % P == 0) begin
            k = m_run / P;
            m_tick = 1;
            if (AR && m_reload != 0) begin
              if (k % m_reload == 0) m_done = 1;
            end else if (k == m_base) begin
              m_done = 1;
              m_mode = M_DONE;
            end
          end
          if (m_mode == M_RUN && ps) m_mode = M_PAUSE;
        end
        M_PAUSE: if (st) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  function automatic int model_cnt();
    int k;
    k = m_run / P;
    if (m_mode == M_IDLE) return m_idle_cnt;
    if (m_mode == M_DONE) return 0;
    if (AR && m_reload != 0) return m_reload - (k % m_reload);
    return m_base - k;
  endfunction

  int done_at[$];
  int busy_bad;
  int exp_n;

  initial begin
    sys_rst_n = 1'b0;
    load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    #3;
    chk("rst_cnt", 32'(cnt_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    #9 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Load 3, run to terminal, DONE behaviour, zero-start
    add(0,0,0,0,1,0,  0,0,0,0);
    add(1,3,0,0,0,0,  3,0,0,0);
    add(0,0,1,0,0,6,  3,1,0,0);
    add(0,0,0,0,0,0,  3,1,0,0);
    add(0,0,0,0,0,0,  2,1,1,0);
    add(0,0,0,0,0,0,  2,1,0,0);
    add(0,0,0,0,0,6,  1,1,1,0);
    add(0,0,0,0,0,7,  AR ? 3 : 0, AR,1,1);
    add(0,0,0,0,0,0,  AR ? 3 : 0, AR,0,0);
    add(0,0,1,0,0,3,  AR ? 3 : 0, AR,0,0);
    add(0,0,0,0,1,0,  0,0,0,0);
    add(0,0,1,0,0,2,  0,0,0,0);
    // Pause at cycle 5 for 20 cycles
    add(1,3,0,0,0,0,  3,0,0,0);
    add(0,0,1,0,0,4,  3,1,0,0);
    add(0,0,0,1,0,0,  3,1,0,0);
    add(0,0,0,0,0,18, 3,1,0,0);
    add(0,0,1,0,0,2,  3,1,0,0);
    add(0,0,0,0,0,0,  2,1,1,0);
    add(0,0,0,0,0,14, 1,1,0,0);
    add(0,0,0,0,0,0,  AR ? 3 : 0, AR,1,1);
    // Reload mid-run
    add(1,5,0,0,0,0,  5,0,0,0);
    add(0,0,1,0,0,9,  4,1,0,0);
    add(1,2,0,0,0,0,  2,0,0,0);
    add(0,0,0,0,0,7,  2,0,0,0);
    add(0,0,1,0,0,15, 1,1,0,0);
    add(0,0,0,0,0,0,  AR ? 2 : 0, AR,1,1);
    add(1,7,0,0,1,0,  0,0,0,0);
    // Pause on the same edge as a decrement
    add(1,3,0,0,0,0,  3,0,0,0);
    add(0,0,1,0,0,6,  3,1,0,0);
    add(0,0,0,0,0,0,  3,1,0,0);
    add(0,0,0,1,0,0,  2,1,1,0);
    add(0,0,0,0,0,5,  2,1,0,0);
    add(0,0,1,0,0,7,  2,1,0,0);
    add(0,0,0,0,0,0,  1,1,1,0);
    add(0,0,0,0,1,0,  0,0,0,0);
    // start and pause together in IDLE, RUN, PAUSE
    add(1,2,0,0,0,0,  2,0,0,0);
    add(0,0,1,1,0,0,  2,1,0,0);
    add(0,0,1,1,0,0,  2,1,0,0);
    add(0,0,1,1,0,0,  2,1,0,0);
    add(0,0,0,0,0,4,  2,1,0,0);
    add(0,0,0,0,0,0,  2,1,0,0);
    add(0,0,0,0,0,0,  1,1,1,0);
    add(0,0,0,0,1,0,  0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].ps, tbl[i].cl);
      repeat (tbl[i].ext) begin
        @(posedge sys_clk);
        #1;
      end
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_out), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].tk));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].dn));
    end

    // done positions over 50 cycles after loading 2
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    busy_bad = 0;
    for (int e = 1; e <= 50; e++) begin
      drive(0, 0, 0, 0, 0);
      if (done === 1'b1) done_at.push_back(e);
      if (busy !== ((AR || e < 16) ? 1'b1 : 1'b0)) busy_bad++;
    end
    exp_n = AR ? 3 : 1;
    chk("done_count", 32'(done_at.size()), 32'(exp_n));
    for (int j = 0; j < exp_n && j < done_at.size(); j++)
      chk($sformatf("done_at%0d", j), 32'(done_at[j]), 32'(16 * (j + 1)));
    chk("busy_trace_bad", 32'(busy_bad), 0);

    // Async reset while a tick is on the outputs
    drive(1, 3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 0);
    chk("pre_rst_tick", 32'(tick), 1);
    chk("pre_rst_cnt", 32'(cnt_out), 2);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Random traffic against the model
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rl, rs, rp, rc;
      int rv;
      rl = ($urandom_range(29) == 0);
      rv = int'($urandom_range(4));
      rs = ($urandom_range(5) == 0);
      rp = ($urandom_range(11) == 0);
      rc = ($urandom_range(59) == 0);
      model_step(rl, rv, rs, rp, rc);
      drive(rl, rv, rs, rp, rc);
      chk($sformatf("rnd%0d_cnt", c), 32'(cnt_out), 32'(model_cnt()));
      chk($sformatf("rnd%0d_busy", c), 32'(busy),
          32'(m_mode == M_RUN || m_mode == M_PAUSE));
      chk($sformatf("rnd%0d_tick", c), 32'(tick), 32'(m_tick));
      chk($sformatf("rnd%0d_done", c), 32'(done), 32'(m_done));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
